// File: rtl/pipe_ctrl_pkg.sv
// Shared core defines for the pipeline controller: PC/jump address span,
// default redirect bubble length and the controller FSM state encodings.
package pipe_ctrl_pkg;

  localparam int PORT_ADDR_WIDTH  = 32;
  localparam int FLUSH_CYCLES_DEF = 2;
  // Wide enough for the legal FLUSH_CYCLES range 1..7.
  localparam int FLUSH_CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_HOLD_PEND = 2'd2,
    ST_TRAP_WAIT = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counters for the pipeline controller: cycles spent
// holding the PC and number of PC redirects issued. Only built when
// PIPE_CTRL_PERF_EN is defined.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_evt,
  input  logic        redirect_evt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // Count up by one when the event fires, sticking at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

  // Both counters clear on reset and accumulate one event per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, stall_evt);
      flush_cnt <= sat_inc(flush_cnt, redirect_evt);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller. Arbitrates EX-stage jumps and traps
// against PC hold sources (fetch stall, busy divider), issues zero-latency
// PC redirects with a flush window, and defers redirects that arrive while
// the PC is held. Optional perf counters are enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = PORT_ADDR_WIDTH,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_jump_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  output logic              trap_ack_o,
  input  logic              div_busy_i,
  input  logic              fetch_stall_i,
  output logic              hold_flag_o,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              flush_o,
  output logic [1:0]        state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  // Flush cycles still owed after the redirect cycle itself.
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_TAIL = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  pipe_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]        pend_q, pend_d;

  logic                     hold;
  logic                     trap_go;
  logic                     redirect;
  logic [ADDR_W-1:0]        target;
  logic                     ack;
  logic                     flush;

  // State, flush counter and deferred jump target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state, redirect arbitration and hold generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    redirect = 1'b0;
    target   = '0;
    ack      = 1'b0;
    flush    = 1'b0;

    // A trap can be taken once nothing is holding the PC; in TRAP_WAIT the
    // wait-hold is released in the very cycle the trap is taken so the
    // redirect is not masked by its own hold.
    trap_go = trap_req_i & ~div_busy_i & ~fetch_stall_i;
    hold    = fetch_stall_i | div_busy_i | ((state_q == ST_TRAP_WAIT) & ~trap_go);

    unique case (state_q)
      ST_RUN, ST_HOLD_PEND: begin
        if (trap_req_i) begin
          // Trap wins over a new or deferred jump; the jump is discarded.
          pend_d = '0;
          if (hold) begin
            state_d = ST_TRAP_WAIT;
          end else begin
            ack      = 1'b1;
            redirect = 1'b1;
            target   = trap_addr_i;
          end
        end else if (state_q == ST_RUN) begin
          if (ex_jump_i) begin
            if (hold) begin
              pend_d  = ex_jump_addr_i;
              state_d = ST_HOLD_PEND;
            end else begin
              redirect = 1'b1;
              target   = ex_jump_addr_i;
            end
          end
        end else if (!hold) begin
          // Deferred jump issues on the first unheld cycle; later EX jumps
          // seen while pending are ignored.
          redirect = 1'b1;
          target   = pend_q;
          pend_d   = '0;
        end
      end
      ST_FLUSH: begin
        // Wrong-path jumps and traps are not looked at; the bubble count
        // only advances on cycles where the pipeline actually moves.
        flush = 1'b1;
        if (!hold) begin
          if (cnt_q <= FLUSH_CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - FLUSH_CNT_W'(1);
          end
        end
      end
      ST_TRAP_WAIT: begin
        if (!trap_req_i) begin
          state_d = ST_RUN;
        end else if (trap_go) begin
          ack      = 1'b1;
          redirect = 1'b1;
          target   = trap_addr_i;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Every redirect flushes in its own cycle and opens the flush window.
    if (redirect) begin
      flush   = 1'b1;
      cnt_d   = FLUSH_TAIL;
      state_d = (FLUSH_CYCLES <= 1) ? ST_RUN : ST_FLUSH;
    end
  end

  // Outputs are forced low for as long as reset is asserted.
  always_comb begin
    hold_flag_o = rst_n & hold;
    jump_flag_o = rst_n & redirect;
    jump_addr_o = (rst_n & redirect) ? target : '0;
    flush_o     = rst_n & flush;
    trap_ack_o  = rst_n & ack;
    state_o     = state_q;
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_evt    (hold_flag_o),
    .redirect_evt (jump_flag_o),
    .stall_cnt    (stall_cnt_o),
    .flush_cnt    (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the controller.
module tb_pipe_ctrl;

  localparam int AW = 32;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_jump_i = 1'b0;
  logic [AW-1:0] ex_jump_addr_i = '0;
  logic          trap_req_i = 1'b0;
  logic [AW-1:0] trap_addr_i = '0;
  logic          div_busy_i = 1'b0;
  logic          fetch_stall_i = 1'b0;
  logic          trap_ack_o, hold_flag_o, jump_flag_o, flush_o;
  logic [AW-1:0] jump_addr_o;
  logic [1:0]    state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   stall_cnt_o, flush_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Observed output bundle: hold, jump, addr, flush, ack, state.
  logic [37:0] obs;
  assign obs = {hold_flag_o, jump_flag_o, jump_addr_o, flush_o, trap_ack_o, state_o};

  // Behavioural model state.
  bit          m_pending, m_wait;
  int          m_flush_left;
  logic [31:0] m_pend_addr;
  logic        e_hold, e_jump, e_flush, e_ack;
  logic [31:0] e_addr;
  logic [1:0]  e_state;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_jump_i      (ex_jump_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .trap_req_i     (trap_req_i),
    .trap_addr_i    (trap_addr_i),
    .trap_ack_o     (trap_ack_o),
    .div_busy_i     (div_busy_i),
    .fetch_stall_i  (fetch_stall_i),
    .hold_flag_o    (hold_flag_o),
    .jump_flag_o    (jump_flag_o),
    .jump_addr_o    (jump_addr_o),
    .flush_o        (flush_o),
    .state_o        (state_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  function automatic logic [37:0] pack(input logic h, input logic j, input logic [31:0] a,
                                       input logic f, input logic k, input logic [1:0] s);
    return {h, j, a, f, k, s};
  endfunction

  task automatic idle();
    ex_jump_i = 1'b0; ex_jump_addr_i = '0; trap_req_i = 1'b0; trap_addr_i = '0;
    div_busy_i = 1'b0; fetch_stall_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_stall_i = 1'b1; div_busy_i = 1'b1; ex_jump_i = 1'b1; trap_req_i = 1'b1;
    ex_jump_addr_i = 32'h1234; trap_addr_i = 32'h5678;
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (obs !== pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0))
      $display("FAIL reset_outputs got=%h exp=%h", obs, pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0));
    else n_pass++;
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if ({stall_cnt_o, flush_cnt_o} !== 64'h0)
      $display("FAIL reset_perf got=%h/%h exp=0/0", stall_cnt_o, flush_cnt_o);
    else n_pass++;
`endif
    idle();
    rst_n = 1'b1;
    next_cycle();
    settle();
    n_checks++;
    if (obs !== pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0))
      $display("FAIL reset_release_idle got=%h exp=%h", obs, pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0));
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_jump_run();
    ex_jump_i = 1'b1; ex_jump_addr_i = 32'h100;
    settle();
    n_checks++;
    if (obs !== pack(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 2'd0))
      $display("FAIL jump_run_redirect got=%h exp=%h", obs, pack(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 2'd0));
    else n_pass++;
    next_cycle();
    ex_jump_addr_i = 32'h555;
    settle();
    n_checks++;
    if (obs !== pack(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd1))
      $display("FAIL jump_run_flush got=%h exp=%h", obs, pack(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd1));
    else n_pass++;
    next_cycle();
    idle();
    settle();
    n_checks++;
    if (obs !== pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0))
      $display("FAIL jump_run_back got=%h exp=%h", obs, pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0));
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_jump_stall();
    logic [37:0] exp_v [6];
    exp_v[0] = pack(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0);
    exp_v[1] = pack(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 2'd2);
    exp_v[2] = pack(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 2'd2);
    exp_v[3] = pack(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 2'd2);
    exp_v[4] = pack(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 2'd1);
    exp_v[5] = pack(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0);
    for (int c = 0; c < 6; c++) begin
      idle();
      fetch_stall_i = (c < 3);
      ex_jump_i = (c < 2);
      ex_jump_addr_i = (c == 0) ? 32'h200 : 32'h300;
      settle();
      n_checks++;
      if (obs !== exp_v[c]) $display("FAIL jump_stall_c%0d got=%h exp=%h", c, obs, exp_v[c]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_flush_freeze();
    logic [37:0] exp_v [5];
    exp_v[0] = pack(1'b0, 1'b1, 32'h3C0, 1'b1, 1'b0, 2'd0);
    exp_v[1] = pack(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 2'd1);
    exp_v[2] = pack(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 2'd1);
    exp_v[3] = pack(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 2'd1);
    exp_v[4] = pack(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0);
    for (int c = 0; c < 5; c++) begin
      idle();
      ex_jump_i = (c == 0);
      ex_jump_addr_i = 32'h3C0;
      fetch_stall_i = (c == 1 || c == 2);
      settle();
      n_checks++;
      if (obs !== exp_v[c]) $display("FAIL flush_freeze_c%0d got=%h exp=%h", c, obs, exp_v[c]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_trap_collision();
    int acks = 0;
    logic [37:0] exp_v [3];
    exp_v[0] = pack(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 2'd0);
    exp_v[1] = pack(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'd1);
    exp_v[2] = pack(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0);
    for (int c = 0; c < 3; c++) begin
      idle();
      trap_req_i = (c == 0); trap_addr_i = 32'h80;
      ex_jump_i = (c < 2); ex_jump_addr_i = 32'h100;
      settle();
      acks += int'(trap_ack_o);
      n_checks++;
      if (obs !== exp_v[c]) $display("FAIL trap_collision_c%0d got=%h exp=%h", c, obs, exp_v[c]);
      else n_pass++;
      next_cycle();
    end
    n_checks++;
    if (acks != 1) $display("FAIL trap_collision_ack_count got=%0d exp=1", acks);
    else n_pass++;
  endtask

  task automatic test_trap_div();
    logic [37:0] ev;
    for (int c = 0; c < 8; c++) begin
      idle();
      div_busy_i = (c < 5);
      trap_req_i = (c < 6); trap_addr_i = 32'h40;
      settle();
      if (c < 5)       ev = pack(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, (c == 0) ? 2'd0 : 2'd3);
      else if (c == 5) ev = pack(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 2'd3);
      else if (c == 6) ev = pack(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'd1);
      else             ev = pack(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0);
      n_checks++;
      if (obs !== ev) $display("FAIL trap_div_c%0d got=%h exp=%h", c, obs, ev);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_trap_drop();
    logic [37:0] exp_v [4];
    exp_v[0] = pack(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    exp_v[1] = pack(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd3);
    exp_v[2] = pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    exp_v[3] = pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    for (int c = 0; c < 4; c++) begin
      idle();
      div_busy_i = (c < 2);
      trap_req_i = (c == 0); trap_addr_i = 32'h90;
      settle();
      n_checks++;
      if (obs !== exp_v[c]) $display("FAIL trap_drop_c%0d got=%h exp=%h", c, obs, exp_v[c]);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    fetch_stall_i = 1'b1; ex_jump_i = 1'b1; ex_jump_addr_i = 32'h700;
    next_cycle();
    ex_jump_i = 1'b0;
    settle();
    n_checks++;
    if (obs !== pack(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2))
      $display("FAIL reset_mid_pending got=%h exp=%h", obs, pack(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2));
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0))
      $display("FAIL reset_mid_outputs got=%h exp=%h", obs, pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0));
    else n_pass++;
    next_cycle();
    idle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      n_checks++;
      if (obs !== pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0))
        $display("FAIL reset_mid_after_c%0d got=%h exp=%h", c, obs, pack(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0));
      else n_pass++;
      next_cycle();
    end
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if ({stall_cnt_o, flush_cnt_o} !== 64'h0)
      $display("FAIL reset_mid_perf got=%h/%h exp=0/0", stall_cnt_o, flush_cnt_o);
    else n_pass++;
`endif
  endtask

  // Model of the controller rules: computes this cycle's expected outputs
  // from the current inputs, then advances to next cycle's situation.
  task automatic model_step();
    logic quiet, redir;
    logic [31:0] tgt;
    quiet   = !fetch_stall_i && !div_busy_i;
    e_state = (m_flush_left > 0) ? 2'd1 : m_wait ? 2'd3 : m_pending ? 2'd2 : 2'd0;
    e_hold  = !quiet || (m_wait && !(trap_req_i && quiet));
    e_flush = (m_flush_left > 0);
    e_ack = 1'b0; redir = 1'b0; tgt = '0;
    if (m_flush_left > 0) begin
      if (!e_hold) m_flush_left--;
    end else if (m_wait) begin
      if (!trap_req_i) m_wait = 0;
      else if (quiet) begin e_ack = 1'b1; redir = 1'b1; tgt = trap_addr_i; m_wait = 0; end
    end else if (trap_req_i) begin
      m_pending = 0;
      if (quiet) begin e_ack = 1'b1; redir = 1'b1; tgt = trap_addr_i; end
      else m_wait = 1;
    end else if (m_pending) begin
      if (quiet) begin redir = 1'b1; tgt = m_pend_addr; m_pending = 0; end
    end else if (ex_jump_i) begin
      if (quiet) begin redir = 1'b1; tgt = ex_jump_addr_i; end
      else begin m_pending = 1; m_pend_addr = ex_jump_addr_i; end
    end
    e_jump = redir;
    e_addr = tgt;
    if (redir) begin e_flush = 1'b1; m_flush_left = FC - 1; end
  endtask

  task automatic test_random();
    int busy_left = 0;
    bit drop_trap = 0;
    logic [37:0] ev;
    idle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    m_pending = 0; m_wait = 0; m_flush_left = 0; m_pend_addr = '0;
    m_stall_cnt = '0; m_flush_cnt = '0;
    for (int c = 0; c < 1500; c++) begin
      if (drop_trap) trap_req_i = 1'b0;
      else if (!trap_req_i) begin
        if ($urandom_range(0, 19) == 0) begin trap_req_i = 1'b1; trap_addr_i = $urandom & 32'hFFFF_FFFC; end
      end else if ($urandom_range(0, 29) == 0) trap_req_i = 1'b0;
      if (busy_left > 0) begin div_busy_i = 1'b1; busy_left--; end
      else begin
        div_busy_i = 1'b0;
        if ($urandom_range(0, 14) == 0) busy_left = int'($urandom_range(1, 6));
      end
      fetch_stall_i  = ($urandom_range(0, 3) == 0);
      ex_jump_i      = ($urandom_range(0, 2) == 0);
      ex_jump_addr_i = $urandom & 32'hFFFF_FFFC;
      settle();
      model_step();
      drop_trap = e_ack;
      ev = pack(e_hold, e_jump, e_addr, e_flush, e_ack, e_state);
      n_checks++;
      if (obs !== ev) $display("FAIL random_c%0d got=%h exp=%h", c, obs, ev);
      else n_pass++;
`ifdef PIPE_CTRL_PERF_EN
      n_checks++;
      if ({stall_cnt_o, flush_cnt_o} !== {m_stall_cnt, m_flush_cnt})
        $display("FAIL random_perf_c%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt_o, flush_cnt_o, m_stall_cnt, m_flush_cnt);
      else n_pass++;
      m_stall_cnt += {31'd0, e_hold};
      m_flush_cnt += {31'd0, e_jump};
`endif
      next_cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_jump_run();
    test_jump_stall();
    test_flush_freeze();
    test_trap_collision();
    test_trap_div();
    test_trap_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 32, PC/jump address width; equals shared PORT_ADDR_WIDTH span.
REQ-002 SHALL have parameter FLUSH_CYCLES, 2, bubble cycles inserted after a redirect (legal 1..7).
REQ-003 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: ex_jump_i  in  1  branch/jump resolved in EX; ex_jump_addr_i  in  ADDR_W  its target.
REQ-005 SHALL have ports: trap_req_i  in  1  trap/interrupt request, level, held until ack; trap_addr_i  in  ADDR_W  trap vector.
REQ-006 SHALL have ports: trap_ack_o  out  1  one-cycle acceptance pulse; div_busy_i  in  1  multi-cycle divider active; fetch_stall_i  in  1  instruction bus not ready.
REQ-007 SHALL have ports: hold_flag_o  out  1  PC/pipeline hold; jump_flag_o  out  1  PC redirect strobe; jump_addr_o  out  ADDR_W  redirect target; flush_o  out  1  kill IF/ID and ID/EX contents; state_o  out  2  current FSM state.

Function
REQ-008 SHALL implement FSM states RUN=0, FLUSH=1, HOLD_PEND=2, TRAP_WAIT=3; state_o mirrors state register.
REQ-009 SHALL drive hold_flag_o = fetch_stall_i | div_busy_i | (state==TRAP_WAIT), combinationally.
REQ-010 SHALL, because PC hold overrides jump, never assert jump_flag_o in a cycle where hold_flag_o is 1.
REQ-011 SHALL, in RUN with ex_jump_i=1 and hold_flag_o=0, assert jump_flag_o and flush_o in the same cycle (zero latency), jump_addr_o=ex_jump_addr_i, then enter FLUSH.
REQ-012 SHALL, in RUN with ex_jump_i=1 and hold_flag_o=1, latch ex_jump_addr_i into pend_addr and enter HOLD_PEND; no jump_flag_o that cycle.
REQ-013 SHALL, in HOLD_PEND, ignore further ex_jump_i; on first cycle hold_flag_o=0, assert jump_flag_o with jump_addr_o=pend_addr plus flush_o, and enter FLUSH.
REQ-014 SHALL, in FLUSH, hold flush_o=1 for FLUSH_CYCLES cycles total including the redirect cycle; the counter freezes while hold_flag_o=1; ex_jump_i is ignored (wrong-path); then return to RUN.
REQ-015 SHALL evaluate trap_req_i only in RUN or HOLD_PEND; trap has priority over ex_jump_i and over a pending jump, which is discarded.
REQ-016 SHALL, on trap_req_i with div_busy_i=1, enter TRAP_WAIT; with div_busy_i=0 and fetch_stall_i=0, pulse trap_ack_o, assert jump_flag_o with jump_addr_o=trap_addr_i plus flush_o, and enter FLUSH.
REQ-017 SHALL, in TRAP_WAIT, remain until div_busy_i=0 and fetch_stall_i=0, then act as REQ-016 on the next cycle (TRAP_WAIT hold is dropped combinationally that cycle).
REQ-018 SHALL drive jump_addr_o=0 whenever jump_flag_o=0.
REQ-019 SHALL drop a trap silently if trap_req_i deasserts before ack; TRAP_WAIT then returns to RUN.

Reset
REQ-020 SHALL, on rst_n low at any time, force state RUN, FLUSH counter 0 and pend_addr 0, and all outputs 0 including hold_flag_o.
REQ-021 SHALL abandon any pending jump or trap on reset mid-operation; no redirect issued after release.

Configuration
REQ-022 SHALL, with PIPE_CTRL_PERF_EN defined, add outputs stall_cnt_o (out 32, cycles with hold_flag_o=1) and flush_cnt_o (out 32, count of redirects), both reset to 0 and saturating at all-ones.
REQ-023 SHALL, without PIPE_CTRL_PERF_EN, omit those ports and counters entirely; other behaviour identical.

Structure
REQ-024 SHALL place FSM state encodings and FLUSH_CYCLES default in the shared core defines package alongside PORT_ADDR_WIDTH.
REQ-025 SHALL be a single module; the optional perf counters form sub-module pipe_perf_cnt.

Verification
REQ-026 Jump in RUN, no hold: ex_jump_i=1, addr 0x100 -> same cycle jump_flag_o=1, jump_addr_o=0x100, flush_o=1 for 2 cycles, back to RUN.
REQ-027 Jump under stall: fetch_stall_i=1 for 3 cycles, ex_jump_i=1 addr 0x200 in cycle 1 -> HOLD_PEND, no jump while stalled, jump_flag_o with 0x200 in first unstalled cycle.
REQ-028 Trap vs jump collision: trap_req_i and ex_jump_i same RUN cycle, trap_addr_i 0x80 -> redirect to 0x80, trap_ack_o pulses once, 0x100 never issued.
REQ-029 Trap during divide: div_busy_i=1 for 5 cycles, trap_req_i raised cycle 0 -> TRAP_WAIT, hold_flag_o=1 throughout, ack and redirect one cycle after div_busy_i falls.
REQ-030 Reset mid-HOLD_PEND: assert rst_n low -> all outputs 0 immediately; after release no jump_flag_o; with PIPE_CTRL_PERF_EN counters read 0.
